// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port data memory between the instruction-fetch port (I)
//   and the memory-stage port (D). Reads take READ_LATENCY cycles in READ and
//   return data with a one-cycle rvalid pulse; writes take one WRITE cycle.
//   D has priority, but once the I port has lost STARVE_LIMIT consecutive
//   arbitrations it wins the next one.
// Ports
//   clk, rst_n                     clock, async active-low reset
//   d_req/d_we/d_addr/d_wdata      D request (held until d_ready)
//   d_ready, d_rvalid, d_rdata     D accept / read return
//   i_req/i_addr                   I read request (held until i_ready)
//   i_ready, i_rvalid, i_rdata     I accept / read return
//   mem_addr/mem_wdata/mem_we      to data memory
//   mem_rdata                      from data memory
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [3:0] LP_LAST   = 4'(READ_LATENCY - 1);
  localparam logic [3:0] LP_STARVE = 4'(STARVE_LIMIT);

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [3:0]        r_starve;
  logic              r_owner_i;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_d_rdata;
  logic [31:0]       r_i_rdata;
  logic              r_d_rvalid;
  logic              r_i_rvalid;

  logic w_idle;
  logic w_grant_i;
  logic w_grant_d;

  assign w_idle = (r_state == S_IDLE);

  // A starved I port overrides D priority; otherwise I only wins when D idles.
  assign w_grant_i = i_req && ((r_starve >= LP_STARVE) || !d_req);
  assign w_grant_d = d_req && !w_grant_i;

  // Ready is forced low while reset is held so nothing is accepted in reset.
  assign d_ready = rst_n && w_idle && w_grant_d;
  assign i_ready = rst_n && w_idle && w_grant_i;

  assign d_rvalid  = r_d_rvalid;
  assign i_rvalid  = r_i_rvalid;
  assign d_rdata   = r_d_rdata;
  assign i_rdata   = r_i_rdata;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = (r_state == S_WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_owner_i  <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_d_rdata  <= '0;
      r_i_rdata  <= '0;
      r_d_rvalid <= 1'b0;
      r_i_rvalid <= 1'b0;
    end else begin
      r_d_rvalid <= 1'b0;
      r_i_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Counts only arbitrations I actually lost to D; anything else clears.
          if (i_req && w_grant_d)
            r_starve <= (r_starve == 4'hF) ? r_starve : r_starve + 4'd1;
          else
            r_starve <= '0;
          if (w_grant_i) begin
            r_owner_i <= 1'b1;
            r_addr    <= i_addr;
            r_cnt     <= '0;
            r_state   <= S_READ;
          end else if (w_grant_d) begin
            r_owner_i <= 1'b0;
            r_addr    <= d_addr;
            r_cnt     <= '0;
            if (d_we) begin
              r_wdata <= d_wdata;
              r_state <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LP_LAST) begin
            if (r_owner_i) begin
              r_i_rdata  <= mem_rdata;
              r_i_rvalid <= 1'b1;
            end else begin
              r_d_rdata  <= mem_rdata;
              r_d_rvalid <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default build (READ_LATENCY = 3, STARVE_LIMIT = 4)
  logic        d_req = 0, d_we = 0, i_req = 0;
  logic [31:0] d_addr = 0, d_wdata = 0, i_addr = 0;
  logic        d_ready, d_rvalid, i_ready, i_rvalid, mem_we;
  logic [31:0] d_rdata, i_rdata, mem_addr, mem_wdata, mem_rdata;

  // READ_LATENCY = 1 build
  logic        b_d_req = 0, b_d_we = 0, b_i_req = 0;
  logic [31:0] b_d_addr = 0, b_d_wdata = 0, b_i_addr = 0;
  logic        b_d_ready, b_d_rvalid, b_i_ready, b_i_rvalid, b_mem_we;
  logic [31:0] b_d_rdata, b_i_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [31:0] mem [0:63];

  // Word-indexed memory model; preloaded on reset, written by the default build.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'hC0DE_0000 + k;
      mem[4] <= 32'hDEAD_BEEF;
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end
  assign mem_rdata   = mem[mem_addr[7:2]];
  assign b_mem_rdata = mem[b_mem_addr[7:2]];

  mem_port_arbiter #(.ADDR_W(32), .READ_LATENCY(3), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .i_req(i_req), .i_addr(i_addr),
    .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .READ_LATENCY(1), .STARVE_LIMIT(4)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ready(b_d_ready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .i_req(b_i_req), .i_addr(b_i_addr),
    .i_ready(b_i_ready), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("rst d_ready", d_ready, 0);
    chk("rst i_ready", i_ready, 0);
    chk("rst d_rvalid", d_rvalid, 0);
    chk("rst i_rvalid", i_rvalid, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    chk("rst i_rdata", i_rdata, 0);
    chk("rst state", 32'(dut.r_state), 0);
    chk("rst starve", 32'(dut.r_starve), 0);
    step(); step();
    rst_n = 1;
    step();

    // ---------------- single D read of 0x10 ----------------
    d_req = 1; d_we = 0; d_addr = 32'h10; #1;
    chk("rd c0 d_ready", d_ready, 1);
    chk("rd c0 i_ready", i_ready, 0);
    for (int c = 1; c <= 3; c++) begin
      step(); d_req = 0; #1;
      chk("rd c1-3 mem_addr", mem_addr, 32'h10);
      chk("rd c1-3 d_rvalid", d_rvalid, 0);
      chk("rd c1-3 d_ready", d_ready, 0);
      chk("rd c1-3 mem_we", mem_we, 0);
    end
    step(); #1;
    chk("rd c4 d_rvalid", d_rvalid, 1);
    chk("rd c4 d_rdata", d_rdata, 32'hDEAD_BEEF);
    chk("rd c4 i_rvalid", i_rvalid, 0);
    step(); #1;
    chk("rd c5 d_rvalid", d_rvalid, 0);
    chk("rd c5 d_rdata hold", d_rdata, 32'hDEAD_BEEF);

    // ---------------- D write 0x20 ----------------
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h1234_5678; #1;
    chk("wr c0 d_ready", d_ready, 1);
    chk("wr c0 mem_we", mem_we, 0);
    step(); d_req = 0; d_we = 0; #1;
    chk("wr c1 mem_we", mem_we, 1);
    chk("wr c1 mem_addr", mem_addr, 32'h20);
    chk("wr c1 mem_wdata", mem_wdata, 32'h1234_5678);
    chk("wr c1 d_ready", d_ready, 0);
    step(); #1;
    chk("wr c2 mem_we", mem_we, 0);
    chk("wr c2 d_rvalid", d_rvalid, 0);
    chk("wr c2 mem_wdata hold", mem_wdata, 32'h1234_5678);

    // read back 0x20
    d_req = 1; d_addr = 32'h20; #1;
    chk("rb c0 d_ready", d_ready, 1);
    step(); d_req = 0;
    step(); step(); step(); #1;
    chk("rb c4 d_rvalid", d_rvalid, 1);
    chk("rb c4 d_rdata", d_rdata, 32'h1234_5678);
    step();

    // ---------------- simultaneous D(0x4) and I(0x8) ----------------
    d_req = 1; d_addr = 32'h4; i_req = 1; i_addr = 32'h8; #1;
    chk("sim c0 d_ready", d_ready, 1);
    chk("sim c0 i_ready", i_ready, 0);
    for (int c = 1; c <= 3; c++) begin
      step(); d_req = 0; #1;
      chk("sim c1-3 i_ready", i_ready, 0);
    end
    step(); #1;
    chk("sim c4 d_rvalid", d_rvalid, 1);
    chk("sim c4 d_rdata", d_rdata, 32'hC0DE_0001);
    chk("sim c4 i_ready", i_ready, 1);
    step(); i_req = 0;
    step(); step(); step(); #1;
    chk("sim c8 i_rvalid", i_rvalid, 1);
    chk("sim c8 i_rdata", i_rdata, 32'hC0DE_0002);
    chk("sim c8 d_rvalid", d_rvalid, 0);
    step();

    // ---------------- starvation: both held continuously ----------------
    d_req = 1; d_we = 0; d_addr = 32'h0; i_req = 1; i_addr = 32'hC; #1;
    for (int g = 0; g < 6; g++) begin
      // Expected grant order D,D,D,D,I,D; accepts every 4 cycles.
      chk("stv d_ready", d_ready, (g == 4) ? 0 : 1);
      chk("stv i_ready", i_ready, (g == 4) ? 1 : 0);
      if (g == 5) begin
        chk("stv i_rvalid", i_rvalid, 1);
        chk("stv i_rdata", i_rdata, 32'hC0DE_0003);
      end
      step(); #1;
      if (g == 4) chk("stv starve after I", 32'(dut.r_starve), 0);
      step(); step(); step(); #1;
    end
    d_req = 0; i_req = 0;
    step(); step(); step(); step(); step(); #1;

    // ---------------- reset mid D read ----------------
    d_req = 1; d_addr = 32'h10; #1;
    chk("mrst c0 d_ready", d_ready, 1);
    step(); d_req = 0;
    step();
    rst_n = 0; #1;
    chk("mrst d_ready", d_ready, 0);
    chk("mrst mem_addr", mem_addr, 0);
    chk("mrst mem_we", mem_we, 0);
    chk("mrst d_rdata", d_rdata, 0);
    chk("mrst i_rdata", i_rdata, 0);
    chk("mrst state", 32'(dut.r_state), 0);
    step(); step();
    rst_n = 1; #1;
    for (int c = 0; c < 4; c++) begin
      chk("mrst no d_rvalid", d_rvalid, 0);
      step();
    end
    d_req = 1; d_addr = 32'h10; #1;
    chk("mrst2 c0 d_ready", d_ready, 1);
    step(); d_req = 0; #1;
    chk("mrst2 c1 d_rvalid", d_rvalid, 0);
    step(); step(); step(); #1;
    chk("mrst2 c4 d_rvalid", d_rvalid, 1);
    chk("mrst2 c4 d_rdata", d_rdata, 32'hDEAD_BEEF);
    step();

    // ---------------- READ_LATENCY = 1: alternating D 0x0 / I 0x4 ----------------
    b_d_req = 1; b_d_addr = 32'h0; #1;
    chk("l1 c0 d_ready", b_d_ready, 1);
    for (int p = 0; p < 2; p++) begin
      step(); b_d_req = 0; #1;
      chk("l1 d c1 d_rvalid", b_d_rvalid, 0);
      chk("l1 d c1 i_ready", b_i_ready, 0);
      step(); b_i_req = 1; b_i_addr = 32'h4; #1;
      chk("l1 d c2 d_rvalid", b_d_rvalid, 1);
      chk("l1 d c2 d_rdata", b_d_rdata, 32'hC0DE_0000);
      chk("l1 i c0 i_ready", b_i_ready, 1);
      step(); b_i_req = 0; #1;
      chk("l1 i c1 i_rvalid", b_i_rvalid, 0);
      step(); b_d_req = (p == 0); #1;
      chk("l1 i c2 i_rvalid", b_i_rvalid, 1);
      chk("l1 i c2 i_rdata", b_i_rdata, 32'hC0DE_0001);
      chk("l1 d c0 d_ready", b_d_ready, (p == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
